// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared types and defaults for the programmable serial pattern detector.
//   state_t          : detector FSM encoding (IDLE / FILL / ARMED)
//   LEN_W            : width of a pattern-length field for the default MAX_LEN
//   DEF_*            : default parameter values, including the reset-time
//                      pattern configuration
//   len_width()      : length-field width for an arbitrary MAX_LEN
// ---------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        ARMED = 2'b10
    } state_t;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int LEN_W       = $clog2(DEF_MAX_LEN + 1);

    // Stored 16 bits wide so any legal MAX_LEN (2..16) can slice its default.
    localparam logic [15:0] DEF_RST_PATTERN = 16'h0005;
    localparam int          DEF_RST_LEN     = 3;
    localparam logic        DEF_RST_OVERLAP = 1'b1;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_prog_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value. A clear in the same cycle as
// an increment restarts the count at 1 so that event is not lost.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, count -> 0
//   inc     : count one event this cycle
//   clr     : synchronous clear
//   count   : current count (CNT_W bits)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= CNT_W'(inc);
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/seq_det_prog.sv
// ---------------------------------------------------------------------------
// seq_det_prog
// Run-time programmable serial bit-pattern detector (1..MAX_LEN bits) with
// overlapping / non-overlapping modes, an input valid qualifier and a
// saturating match counter.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   en             : detector enable, low parks the FSM in IDLE
//   seq_in         : serial data, sampled only when seq_valid is high
//   cfg_load       : load cfg_pattern / cfg_len / cfg_overlap (IDLE only)
//   cfg_pattern    : pattern, bit[len-1] is the first bit received
//   cfg_len        : pattern length, legal range 1..MAX_LEN
//   cfg_overlap    : 1 = overlapping matches, 0 = restart after each match
//   cfg_err        : one-cycle pulse when a cfg_load is rejected
//   count_clr      : synchronous clear of det_count
//   det_o          : one-cycle match pulse, one cycle after the final bit
//   det_count      : saturating match count
//   armed          : FSM is in ARMED
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | disabled; config may be loaded; history/fill held clear
// FILL  | fewer than len valid bits collected since entry or last restart
// ARMED | len bits collected; every valid bit is a match candidate
// ---------------------------------------------------------------------------
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = DEF_MAX_LEN,
    parameter int                 CNT_W       = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = DEF_RST_PATTERN[MAX_LEN-1:0],
    parameter int                 RST_LEN     = DEF_RST_LEN,
    parameter logic               RST_OVERLAP = DEF_RST_OVERLAP
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           en,
    input  logic                           seq_in,
    input  logic                           seq_valid,
    input  logic                           cfg_load,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cfg_overlap,
    output logic                           cfg_err,
    input  logic                           count_clr,
    output logic                           det_o,
    output logic [CNT_W-1:0]               det_count,
    output logic                           armed
);

    localparam int                 L_LEN_W   = len_width(MAX_LEN);
    localparam logic [L_LEN_W-1:0] L_MAX_LEN = L_LEN_W'(MAX_LEN);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [MAX_LEN-1:0]   r_hist;
    logic [MAX_LEN-1:0]   w_hist_nxt;
    logic [MAX_LEN-1:0]   w_hist_shift;
    logic [MAX_LEN-1:0]   w_mask;
    logic [L_LEN_W-1:0]   r_fill;
    logic [L_LEN_W-1:0]   w_fill_nxt;
    logic [L_LEN_W-1:0]   w_fill_inc;

    logic [MAX_LEN-1:0]   r_pattern;
    logic [L_LEN_W-1:0]   r_len;
    logic                 r_overlap;

    logic                 r_det;
    logic                 r_err;
    logic                 w_step;
    logic                 w_match;
    logic                 w_len_ok;
    logic                 w_cfg_acc;

    // ------------------------------------------------------------------
    // Datapath candidates for the current edge
    // ------------------------------------------------------------------
    assign w_step       = en && seq_valid && (r_state != IDLE);
    assign w_hist_shift = {r_hist[MAX_LEN-2:0], seq_in};
    assign w_fill_inc   = (r_fill >= r_len) ? r_len : r_fill + L_LEN_W'(1);

    // Only the low len bits of history and pattern take part in a compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_match = w_step && (w_fill_inc >= r_len)
                     && (((w_hist_shift ^ r_pattern) & w_mask) == '0);

    // ------------------------------------------------------------------
    // Configuration: only a legal length presented while IDLE is taken
    // ------------------------------------------------------------------
    assign w_len_ok  = (cfg_len != '0) && (cfg_len <= L_MAX_LEN);
    assign w_cfg_acc = cfg_load && (r_state == IDLE) && w_len_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pattern <= RST_PATTERN;
            r_len     <= L_LEN_W'(RST_LEN);
            r_overlap <= RST_OVERLAP;
            r_err     <= 1'b0;
        end else begin
            r_err <= cfg_load && !w_cfg_acc;
            if (w_cfg_acc) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state with history / fill
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_hist_nxt  = r_hist;
        w_fill_nxt  = r_fill;
        if (!en) begin
            w_state_nxt = IDLE;
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = FILL;
                    w_hist_nxt  = '0;
                    w_fill_nxt  = '0;
                end
                FILL, ARMED: begin
                    if (seq_valid) begin
                        w_hist_nxt = w_hist_shift;
                        w_fill_nxt = w_fill_inc;
                        // Non-overlap restarts collection so the completing
                        // bit cannot seed the next match.
                        if (w_match && !r_overlap) begin
                            w_fill_nxt  = '0;
                            w_state_nxt = FILL;
                        end else if (w_fill_inc == r_len) begin
                            w_state_nxt = ARMED;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_hist_nxt  = '0;
                    w_fill_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_hist  <= '0;
            r_fill  <= '0;
            r_det   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hist  <= w_hist_nxt;
            r_fill  <= w_fill_nxt;
            r_det   <= w_match;
        end
    end

    // ------------------------------------------------------------------
    // Match counter and outputs
    // ------------------------------------------------------------------
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_det_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (w_match),
        .clr     (count_clr),
        .count   (det_count)
    );

    assign det_o   = r_det;
    assign cfg_err = r_err;
    assign armed   = (r_state == ARMED);

endmodule
